// File: rtl/ad9265_spi_responder_pkg.sv
// ---------------------------------------------------------------------------
// ad9265_pkg
// Shared definitions for the AD9265 configuration-port SPI responder:
//   - register address map (13-bit SPI addresses)
//   - frame / instruction lengths in sclk rising edges
//   - FSM state encoding
//   - soft-reset decode helper for the SPI config register
// ---------------------------------------------------------------------------
package ad9265_pkg;

   // Register map
   localparam logic [12:0] ADDR_SPI_CFG  = 13'h000;
   localparam logic [12:0] ADDR_CHIP_ID  = 13'h001;
   localparam logic [12:0] ADDR_PWR_MODE = 13'h008;
   localparam logic [12:0] ADDR_OUT_MODE = 13'h014;
   localparam logic [12:0] ADDR_VREF     = 13'h018;
   localparam logic [12:0] ADDR_TRANSFER = 13'h0FF;

   // Edge counter wide enough to tell "exactly 24" from "more than 24";
   // it saturates at all-ones so very long frames never wrap back to 24.
   typedef logic [5:0] bit_cnt_t;
   localparam bit_cnt_t FRAME_LEN = 6'd24;
   localparam bit_cnt_t INSTR_LEN = 6'd16;

   // Bits 5 and 2 of register 0x00 together request a soft reset.
   localparam logic [7:0] SOFT_RESET_MASK = 8'h24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INSTR = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   function automatic logic is_soft_reset(input logic [7:0] data);
      return (data & SOFT_RESET_MASK) == SOFT_RESET_MASK;
   endfunction

endpackage

// File: rtl/ad9265_spi_responder_if.sv
// ---------------------------------------------------------------------------
// ad9265_spi_if
// Three-wire SPI pin bundle between the ADC configuration master and the
// AD9265 responder.
//   spi_clk_i    master -> responder  SPI clock (asynchronous to clk)
//   spi_csn_i    master -> responder  chip select, active low
//   spi_sdio_i   master -> responder  SDIO value seen at the pin
//   spi_sdio_o   responder -> master  SDIO read data
//   spi_sdio_oe  responder -> master  1 = responder drives SDIO
// ---------------------------------------------------------------------------
interface ad9265_spi_if;

   logic spi_clk_i;
   logic spi_csn_i;
   logic spi_sdio_i;
   logic spi_sdio_o;
   logic spi_sdio_oe;

   modport master (
      output spi_clk_i,
      output spi_csn_i,
      output spi_sdio_i,
      input  spi_sdio_o,
      input  spi_sdio_oe
   );

   modport slave (
      input  spi_clk_i,
      input  spi_csn_i,
      input  spi_sdio_i,
      output spi_sdio_o,
      output spi_sdio_oe
   );

endinterface

// File: rtl/ad9265_spi_responder_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_pin_sync
// Brings one asynchronous SPI pin into the clk domain through a STAGES-deep
// flip-flop chain and derives single-cycle rise/fall strobes from the
// synchronized level.
//   clk        system clock
//   rst        synchronous, active-high reset
//   pin        asynchronous input pin
//   level      synchronized pin level
//   rise/fall  one-cycle strobes on a 0->1 / 1->0 change of level
// STAGES must be at least 2. RESET_VAL is the idle level of the pin so that
// leaving reset does not fabricate an edge.
// ---------------------------------------------------------------------------
module spi_pin_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // NOTE: clocked state uses non-blocking assignments so every flop in the
   // chain samples its predecessor's old value, forming a real shift chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/ad9265_spi_responder.sv
// ---------------------------------------------------------------------------
// ad9265_spi_responder
// Oversampling SPI slave modelling the AD9265 configuration port. Decodes
// 24-bit frames (R/W, W1W0, 13-bit address, 8-bit data, MSB first), keeps a
// shadow/active register map and returns read data on three-wire SDIO.
//   clk          system clock, >= 8x the SPI clock
//   rst          synchronous, active-high reset
//   spi          SPI pins (slave modport of ad9265_spi_if)
//   pwr_mode     active copy of register 0x08
//   out_mode     active copy of register 0x14
//   vref_cfg     active copy of register 0x18
//   cfg_update   one-cycle pulse when shadows are copied to active
//   frame_done   one-cycle pulse at the end of a valid 24-bit frame
//   frame_err    one-cycle pulse at the end of an invalid frame
// ---------------------------------------------------------------------------
module ad9265_spi_responder
   import ad9265_pkg::*;
#(
   parameter logic [7:0] CHIP_ID         = 8'h64,
   parameter logic [7:0] SPI_CFG_DEFAULT = 8'h18,
   parameter int         SYNC_STAGES     = 2
) (
   input  logic         clk,
   input  logic         rst,
   ad9265_spi_if.slave  spi,
   output logic [7:0]   pwr_mode,
   output logic [7:0]   out_mode,
   output logic [7:0]   vref_cfg,
   output logic         cfg_update,
   output logic         frame_done,
   output logic         frame_err
);

   // ---------------------------------------------------------------------
   // Pin synchronizers
   // ---------------------------------------------------------------------
   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic csn_rise, csn_fall, csn_level_unused;
   logic sdio_level, sdio_rise_unused, sdio_fall_unused;

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi.spi_clk_i),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi.spi_csn_i),
      .level (csn_level_unused),
      .rise  (csn_rise),
      .fall  (csn_fall)
   );

   spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdio (
      .clk   (clk),
      .rst   (rst),
      .pin   (spi.spi_sdio_i),
      .level (sdio_level),
      .rise  (sdio_rise_unused),
      .fall  (sdio_fall_unused)
   );

   // ---------------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------------
   state_t      state_q, state_d;
   bit_cnt_t    bit_cnt_q;
   // 16 bits suffice: after 16 edges it holds the instruction, after 24
   // edges its low byte holds the data byte.
   logic [15:0] frame_sr_q;
   logic [1:0]  w1w0_q;
   logic [12:0] addr_q;
   logic [7:0]  rd_sr_q;
   logic [3:0]  rd_cnt_q;
   logic        rd_bit_q;

   logic        decode;
   logic        commit;
   logic [7:0]  rd_value;
   logic [7:0]  wr_data;
   logic        wr_legal;
   logic        sdio_oe;

   // Register map storage
   logic [7:0]  spi_cfg_q;
   logic [7:0]  pwr_shadow_q, out_shadow_q, vref_shadow_q;

   assign wr_data  = frame_sr_q[7:0];
   assign wr_legal = (w1w0_q == 2'b00);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      decode  = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (csn_fall) state_d = ST_INSTR;
         end
         ST_INSTR: begin
            // One cycle after the 16th rising edge the instruction is whole.
            if (bit_cnt_q == INSTR_LEN) begin
               decode  = 1'b1;
               state_d = frame_sr_q[15] ? ST_RDATA : ST_WDATA;
            end
         end
         ST_WDATA: begin
            if (bit_cnt_q == FRAME_LEN) begin
               commit  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_RDATA: begin
            // Leave once the master has sampled the last presented bit.
            if (rd_cnt_q == 4'd8 && sclk_rise) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_WAIT;
         end
         default: state_d = ST_IDLE;
      endcase
      // Chip-select release ends any frame; a commit in this same cycle
      // still takes effect because the register writes key off 'commit'.
      if (csn_rise) state_d = ST_IDLE;
   end

   // Read mux, evaluated against the instruction at decode time.
   always_comb begin
      rd_value = 8'h00;
      if (frame_sr_q[14:13] == 2'b00) begin
         case (frame_sr_q[12:0])
            ADDR_SPI_CFG:  rd_value = spi_cfg_q;
            ADDR_CHIP_ID:  rd_value = CHIP_ID;
            ADDR_PWR_MODE: rd_value = pwr_shadow_q;
            ADDR_OUT_MODE: rd_value = out_shadow_q;
            ADDR_VREF:     rd_value = vref_shadow_q;
            default:       rd_value = 8'h00;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Shift/count datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         frame_sr_q <= '0;
         w1w0_q     <= '0;
         addr_q     <= '0;
         rd_sr_q    <= '0;
         rd_cnt_q   <= '0;
         rd_bit_q   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
            rd_cnt_q  <= '0;
         end else if (sclk_rise) begin
            // Bits past the 24th are counted but never shifted in.
            if (bit_cnt_q < FRAME_LEN) frame_sr_q <= {frame_sr_q[14:0], sdio_level};
            if (bit_cnt_q != '1)       bit_cnt_q  <= bit_cnt_q + 6'd1;
         end

         if (decode) begin
            w1w0_q   <= frame_sr_q[14:13];
            addr_q   <= frame_sr_q[12:0];
            rd_sr_q  <= rd_value;
            rd_cnt_q <= '0;
         end

         if (state_q == ST_RDATA && sclk_fall && rd_cnt_q < 4'd8) begin
            rd_bit_q <= rd_sr_q[7];
            rd_sr_q  <= {rd_sr_q[6:0], 1'b0};
            rd_cnt_q <= rd_cnt_q + 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Register map and status pulses
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         spi_cfg_q     <= SPI_CFG_DEFAULT;
         pwr_shadow_q  <= 8'h00;
         out_shadow_q  <= 8'h00;
         vref_shadow_q <= 8'h00;
         pwr_mode      <= 8'h00;
         out_mode      <= 8'h00;
         vref_cfg      <= 8'h00;
         cfg_update    <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         cfg_update <= 1'b0;
         if (commit && wr_legal) begin
            case (addr_q)
               ADDR_SPI_CFG: begin
                  if (is_soft_reset(wr_data)) begin
                     spi_cfg_q     <= SPI_CFG_DEFAULT & ~SOFT_RESET_MASK;
                     pwr_shadow_q  <= 8'h00;
                     out_shadow_q  <= 8'h00;
                     vref_shadow_q <= 8'h00;
                     pwr_mode      <= 8'h00;
                     out_mode      <= 8'h00;
                     vref_cfg      <= 8'h00;
                  end else begin
                     spi_cfg_q <= wr_data;
                  end
               end
               ADDR_PWR_MODE: pwr_shadow_q  <= wr_data;
               ADDR_OUT_MODE: out_shadow_q  <= wr_data;
               ADDR_VREF:     vref_shadow_q <= wr_data;
               ADDR_TRANSFER: begin
                  // Self-clearing: nothing is stored, the copy is the effect.
                  if (wr_data[0]) begin
                     pwr_mode   <= pwr_shadow_q;
                     out_mode   <= out_shadow_q;
                     vref_cfg   <= vref_shadow_q;
                     cfg_update <= 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // A csn_rise seen in IDLE belongs to no frame (e.g. after rst).
         frame_done <= csn_rise && (state_q != ST_IDLE) &&
                       (bit_cnt_q == FRAME_LEN) && (w1w0_q == 2'b00);
         frame_err  <= csn_rise && (state_q != ST_IDLE) &&
                       !((bit_cnt_q == FRAME_LEN) && (w1w0_q == 2'b00));
      end
   end

   // Drive SDIO only while read bits are on the line; released in the same
   // cycle chip select goes high.
   assign sdio_oe         = (state_q == ST_RDATA) && (rd_cnt_q != 4'd0) && !csn_rise;
   assign spi.spi_sdio_oe = sdio_oe;
   assign spi.spi_sdio_o  = sdio_oe & rd_bit_q;

endmodule

// File: tb/tb_ad9265_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_ad9265_spi_responder
// Drives directed SPI frames into ad9265_spi_responder and compares its
// behaviour with a frame-level register-map model kept in the bench.
// ---------------------------------------------------------------------------
module tb_ad9265_spi_responder;

   localparam int HALF = 8;   // clk cycles per SPI half period

   logic clk = 1'b0;
   logic rst;
   logic [7:0] pwr_mode, out_mode, vref_cfg;
   logic cfg_update, frame_done, frame_err;

   ad9265_spi_if spi ();

   ad9265_spi_responder #(
      .CHIP_ID         (8'h64),
      .SPI_CFG_DEFAULT (8'h18),
      .SYNC_STAGES     (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi        (spi),
      .pwr_mode   (pwr_mode),
      .out_mode   (out_mode),
      .vref_cfg   (vref_cfg),
      .cfg_update (cfg_update),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse / activity monitors
   int   n_done = 0, n_err = 0, n_upd = 0;
   int   oe_total = 0, oe_instr = 0, oe_samp = 0;
   logic in_frame = 1'b0, phase_instr = 1'b0, idle_chk = 1'b0;

   // Behavioural register map
   logic [7:0] m_cfg;
   logic [7:0] m_sh  [3];
   logic [7:0] m_act [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_cfg = 8'h18;
      for (int i = 0; i < 3; i++) begin
         m_sh[i]  = 8'h00;
         m_act[i] = 8'h00;
      end
   endtask

   function automatic int sh_index(input logic [12:0] a);
      if (a == 13'h008) return 0;
      if (a == 13'h014) return 1;
      if (a == 13'h018) return 2;
      return -1;
   endfunction

   // Frame-level model: what a frame must do to the map and the status lines.
   task automatic model_frame(input logic [23:0] w, input int nbits,
                              output logic done, output logic [7:0] rd, output int upd);
      logic [12:0] a;
      logic [7:0]  d;
      logic        legal;
      int          k;
      a     = w[20:8];
      d     = w[7:0];
      legal = (w[22:21] == 2'b00);
      k     = sh_index(a);
      done  = legal && (nbits == 24);
      rd    = 8'h00;
      upd   = 0;
      if (w[23]) begin
         if (legal) begin
            if (a == 13'h000)      rd = m_cfg;
            else if (a == 13'h001) rd = 8'h64;
            else if (k >= 0)       rd = m_sh[k];
         end
      end else if (legal && nbits >= 24) begin
         if (a == 13'h000) begin
            if (d[5] && d[2]) model_reset();
            else              m_cfg = d;
         end else if (k >= 0) begin
            m_sh[k] = d;
         end else if (a == 13'h0FF && d[0]) begin
            for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
            upd = 1;
         end
      end
   endtask

   // Mode-0 master: data set while sclk low, responder data sampled just
   // before each rising edge.
   task automatic spi_frame(input logic [23:0] w, input int nbits, input logic raise_csn,
                            output logic [7:0] rd);
      logic b;
      rd          = 8'h00;
      idle_chk    = 1'b0;
      oe_total    = 0;
      oe_instr    = 0;
      oe_samp     = 0;
      in_frame    = 1'b1;
      phase_instr = 1'b1;
      spi.spi_csn_i = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < nbits; i++) begin
         b = (i < 24) ? w[23 - i] : 1'b0;
         if (i == 16) phase_instr = 1'b0;
         spi.spi_sdio_i = (w[23] && i >= 16) ? 1'b0 : b;
         wait_clks(HALF);
         if (i >= 16 && i < 24) begin
            rd = {rd[6:0], spi.spi_sdio_o};
            if (spi.spi_sdio_oe) oe_samp++;
         end
         spi.spi_clk_i = 1'b1;
         wait_clks(HALF);
         spi.spi_clk_i = 1'b0;
      end
      phase_instr = 1'b0;
      if (raise_csn) begin
         wait_clks(HALF);
         spi.spi_csn_i = 1'b1;
         wait_clks(12);
         in_frame = 1'b0;
      end
   endtask

   task automatic run_frame(input string name, input logic [23:0] w, input int nbits,
                            output logic [7:0] rd);
      logic       exp_done;
      logic [7:0] exp_rd;
      int         exp_upd;
      int         d0, e0, u0;
      model_frame(w, nbits, exp_done, exp_rd, exp_upd);
      d0 = n_done; e0 = n_err; u0 = n_upd;
      spi_frame(w, nbits, 1'b1, rd);
      check({name, "_done"}, n_done - d0, {31'd0, exp_done});
      check({name, "_err"},  n_err - e0,  {31'd0, !exp_done});
      check({name, "_upd"},  n_upd - u0,  exp_upd);
      if (w[23] && nbits >= 24) begin
         check({name, "_rd"},       rd,       exp_rd);
         check({name, "_oe_bits"},  oe_samp,  8);
         check({name, "_oe_instr"}, oe_instr, 0);
      end else begin
         check({name, "_oe_idle"}, oe_total, 0);
      end
      idle_chk = 1'b1;
      wait_clks(4);
   endtask

   logic [7:0] rd;

   initial begin
      rst            = 1'b1;
      spi.spi_clk_i  = 1'b0;
      spi.spi_csn_i  = 1'b1;
      spi.spi_sdio_i = 1'b0;
      model_reset();

      fork
         begin : compare_loop
            forever begin
               @(negedge clk);
               if (frame_done) n_done++;
               if (frame_err)  n_err++;
               if (cfg_update) n_upd++;
               if (in_frame && spi.spi_sdio_oe) begin
                  oe_total++;
                  if (phase_instr) oe_instr++;
               end
               if (idle_chk) begin
                  check("idle_pwr_mode", pwr_mode, m_act[0]);
                  check("idle_out_mode", out_mode, m_act[1]);
                  check("idle_vref_cfg", vref_cfg, m_act[2]);
                  check("idle_oe",       spi.spi_sdio_oe, 1'b0);
                  check("idle_pulses",   {frame_done, frame_err, cfg_update}, 3'b000);
               end
            end
         end
      join_none

      // Reset state
      wait_clks(5);
      check("rst_pwr_mode", pwr_mode, 8'h00);
      check("rst_out_mode", out_mode, 8'h00);
      check("rst_vref_cfg", vref_cfg, 8'h00);
      check("rst_pulses",   {cfg_update, frame_done, frame_err}, 3'b000);
      check("rst_sdio",     {spi.spi_sdio_oe, spi.spi_sdio_o}, 2'b00);
      rst = 1'b0;
      wait_clks(5);

      // Reads of SPI config and chip id
      run_frame("rd_cfg", 24'h800000, 24, rd);
      check("rd_cfg_lit", rd, 8'h18);
      run_frame("rd_id", 24'h800100, 24, rd);
      check("rd_id_lit", rd, 8'h64);
      check("two_done_lit", n_done, 2);

      // Shadow writes then transfer
      run_frame("wr_pwr",  24'h000880, 24, rd);
      run_frame("wr_out",  24'h001400, 24, rd);
      run_frame("wr_vref", 24'h0018C0, 24, rd);
      check("pre_xfer_pwr_lit",  pwr_mode, 8'h00);
      check("pre_xfer_vref_lit", vref_cfg, 8'h00);
      check("pre_xfer_upd_lit",  n_upd, 0);
      run_frame("xfer", 24'h00FF01, 24, rd);
      check("xfer_pwr_lit",  pwr_mode, 8'h80);
      check("xfer_out_lit",  out_mode, 8'h00);
      check("xfer_vref_lit", vref_cfg, 8'hC0);
      check("xfer_upd_lit",  n_upd, 1);
      run_frame("rd_xfer", 24'h80FF00, 24, rd);
      check("rd_xfer_lit", rd, 8'h00);

      // Truncated frame, then a valid read
      run_frame("trunc", 24'h000855, 20, rd);
      run_frame("rd_pwr_sh", 24'h800800, 24, rd);
      check("rd_pwr_sh_lit", rd, 8'h80);

      // Illegal W1W0 write and read, chip id write
      run_frame("w1w0_wr", 24'h2008AA, 24, rd);
      run_frame("rd_pwr_sh2", 24'h800800, 24, rd);
      check("rd_pwr_sh2_lit", rd, 8'h80);
      run_frame("w1w0_rd", 24'hA00800, 24, rd);
      check("w1w0_rd_lit", rd, 8'h00);
      run_frame("wr_id", 24'h000112, 24, rd);
      run_frame("rd_id2", 24'h800100, 24, rd);
      check("rd_id2_lit", rd, 8'h64);

      // Over-long frame: error, but the first commit stands
      run_frame("long_wr", 24'h000833, 26, rd);
      run_frame("rd_long", 24'h800800, 24, rd);
      check("rd_long_lit", rd, 8'h33);

      // Unmapped address
      run_frame("wr_unmap", 24'h000377, 24, rd);
      run_frame("rd_unmap", 24'h800300, 24, rd);
      check("rd_unmap_lit", rd, 8'h00);

      // Soft reset
      run_frame("sr_vref", 24'h0018C0, 24, rd);
      run_frame("sr_xfer", 24'h00FF01, 24, rd);
      check("sr_pre_vref_lit", vref_cfg, 8'hC0);
      run_frame("soft_rst", 24'h00003C, 24, rd);
      check("sr_vref_lit", vref_cfg, 8'h00);
      check("sr_pwr_lit",  pwr_mode, 8'h00);
      run_frame("sr_rd_cfg", 24'h800000, 24, rd);
      check("sr_rd_cfg_lit", rd, 8'h18);
      run_frame("sr_rd_pwr", 24'h800800, 24, rd);
      check("sr_rd_pwr_lit", rd, 8'h00);

      // Give the active registers something to lose, then rst mid-frame
      run_frame("pre_rst_out", 24'h001455, 24, rd);
      run_frame("pre_rst_xfer", 24'h00FF01, 24, rd);
      check("pre_rst_out_lit", out_mode, 8'h55);
      begin
         int d0, e0;
         d0 = n_done; e0 = n_err;
         spi_frame(24'h000866, 10, 1'b0, rd);
         rst = 1'b1;
         model_reset();
         wait_clks(2);
         spi.spi_csn_i  = 1'b1;
         spi.spi_sdio_i = 1'b0;
         wait_clks(6);
         rst = 1'b0;
         in_frame = 1'b0;
         wait_clks(6);
         check("abort_out_lit",  out_mode, 8'h00);
         check("abort_pwr_lit",  pwr_mode, 8'h00);
         check("abort_oe",       spi.spi_sdio_oe, 1'b0);
         check("abort_no_pulse", (n_done - d0) + (n_err - e0), 0);
      end
      run_frame("post_rst_out",  24'h001401, 24, rd);
      run_frame("post_rst_xfer", 24'h00FF01, 24, rd);
      check("post_rst_out_lit", out_mode, 8'h01);
      run_frame("post_rst_rd_cfg", 24'h800000, 24, rd);
      check("post_rst_rd_cfg_lit", rd, 8'h18);

      idle_chk = 1'b0;
      wait_clks(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ad9265_spi_responder.md
Name: ad9265_spi_responder

Overview:
- Behavioural-synthesizable SPI slave for the AD9265 configuration port.
- Decodes the 24-bit single-byte frames issued by the ADC configuration master and holds a shadow/active register map.
- Returns read data on the three-wire SDIO line.
- Used as an on-board loopback target for bring-up and as the ADC-side model in the configuration testbench. Runs entirely in the clk domain by oversampling the SPI pins.

Parameters:
- CHIP_ID, 8'h64, read-only value returned at address 0x01.
- SPI_CFG_DEFAULT, 8'h18, reset value of register 0x00.
- SYNC_STAGES, 2, synchronizer depth on spi_clk_i, spi_csn_i and spi_sdio_i (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the spi_clk_i frequency.
- rst  in  1  synchronous, active-high reset.
- spi_clk_i  in  1  SPI clock from the master, asynchronous.
- spi_csn_i  in  1  chip select, active low, asynchronous.
- spi_sdio_i  in  1  SDIO input sample.
- spi_sdio_o  out  1  SDIO output data.
- spi_sdio_oe  out  1  SDIO output enable (1 = responder drives the line).
- pwr_mode  out  8  active copy of register 0x08.
- out_mode  out  8  active copy of register 0x14.
- vref_cfg  out  8  active copy of register 0x18.
- cfg_update  out  1  one-cycle pulse when shadow registers are copied to active.
- frame_done  out  1  one-cycle pulse at the end of a valid 24-bit frame.
- frame_err  out  1  one-cycle pulse at the end of an invalid frame.

Behaviour:
- Reset:
  - All outputs are 0, except register 0x00, which is SPI_CFG_DEFAULT.
  - Shadow and active 0x08/0x14/0x18 are 0x00.
  - FSM is in IDLE; bit counter is 0.
- Input path:
  - All three pins pass through SYNC_STAGES flip-flops.
  - sclk_rise and sclk_fall are single-cycle strobes taken from the synchronized spi_clk_i.
  - csn_fall and csn_rise are derived the same way from synchronized spi_csn_i.
- Frame format (MSB first):
  - Bit 23 is R/W (1 = read).
  - Bits 22:21 are W1W0; only 00 is legal.
  - Bits 20:8 are the 13-bit address.
  - Bits 7:0 are data.
  - Data is sampled on sclk_rise.
- FSM states and transitions:
  - IDLE -> INSTR on csn_fall; bit counter cleared.
  - INSTR shifts 16 bits. After the 16th sclk_rise it decodes the address:
    - R/W = 0 -> WDATA.
    - R/W = 1 -> RDATA; the read shift register is loaded.
  - WDATA shifts 8 bits. On the cycle after the 8th sclk_rise it commits the write (if legal), then -> WAIT.
  - RDATA: spi_sdio_oe rises and spi_sdio_o presents bit 7 on the first sclk_fall. Each following sclk_fall shifts out the next bit. After 8 bits have been presented -> WAIT.
  - WAIT holds until csn_rise.
  - csn_rise in any state forces IDLE and spi_sdio_oe = 0 in the same cycle.
- Frame completion:
  - On csn_rise, frame_done pulses if exactly 24 sclk_rise edges were counted and W1W0 = 00.
  - Otherwise frame_err pulses.
  - A frame with more than 24 edges is an error; extra bits are ignored and nothing beyond the first commit is written.
  - A truncated frame performs no write.
- Register map:
  - 0x00 SPI config, R/W. Writing with bits 5 and 2 both set is a soft reset: all shadow and active registers return to reset values, and 0x00 reads back with bits 5 and 2 cleared.
  - 0x01 CHIP_ID, read-only; writes are ignored.
  - 0x08, 0x14, 0x18: writes go to the shadow register. Reads return the shadow value.
  - 0xFF transfer: writing bit0 = 1 copies all shadows to active and pulses cfg_update on the commit cycle. The register self-clears and always reads 0x00.
  - Unmapped addresses: writes are ignored, reads return 0x00, and no error is flagged.
  - W1W0 != 00: no write is committed, and a read of that frame returns 0x00.
- Simultaneous events:
  - rst has priority over everything.
  - A soft reset and the transfer cannot coincide, since there is one address per frame.
  - csn_rise arriving on the same cycle as a commit: the commit completes first, then the FSM goes to IDLE.
  - rst mid-frame returns the FSM to IDLE. The in-progress frame is discarded, and the next csn_fall starts a clean frame.

Decomposition:
- Shared package ad9265_pkg holds:
  - register address constants: ADDR_SPI_CFG, ADDR_CHIP_ID, ADDR_PWR_MODE, ADDR_OUT_MODE, ADDR_VREF, ADDR_TRANSFER;
  - the FSM state encoding;
  - the frame length constant, 24.
- Sub-module spi_pin_sync: SYNC_STAGES synchronizer plus rise/fall edge strobes, instantiated once per pin.

Test Plan:
- Reset, then read 0x00 and 0x01:
  - sdio returns 0x18, then 0x64;
  - spi_sdio_oe is high only during the 8 data bits;
  - frame_done pulses twice.
- Write 0x0008_80, 0x0014_00, 0x0018_C0:
  - pwr_mode and vref_cfg remain 0x00, and no cfg_update;
  - then write 0x00FF_01: pwr_mode = 0x80, out_mode = 0x00, vref_cfg = 0xC0, one cfg_update pulse;
  - read 0xFF returns 0x00.
- Truncated frame (csn high after 20 bits of 0x0008_55): frame_err pulses, shadow 0x08 is unchanged, and the next valid frame is decoded correctly.
- W1W0 = 01 write to 0x08 with 0xAA: frame_err pulses and shadow is unchanged. Write 0x01 = 0x12: frame_done pulses and CHIP_ID still reads 0x64.
- Soft reset: program 0x18 = 0xC0 and transfer, then write 0x0000_3C → vref_cfg = 0x00 and read 0x00 returns 0x18.
- Assert rst after 10 bits of a frame: outputs reset, and a following write of 0x0014_01 followed by a transfer gives out_mode = 0x01.
